// File: rtl/au_pkg.sv
// Shared definitions for the arithmetic-unit library: carry-network
// architecture codes and a ceiling-log2 helper for prefix level counts.
package au_pkg;

    localparam int AU_ARCH_RIPPLE      = 0;
    localparam int AU_ARCH_SKLANSKY    = 1;
    localparam int AU_ARCH_KOGGE_STONE = 2;
    localparam int AU_ARCH_BRENT_KUNG  = 3;

    // Smallest r with 2**r >= n; clog2(1) = 0.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

endpackage

// File: rtl/au_prefix_and.sv
// Exclusive prefix AND: t[0] = 1, t[i] = &p[i-1:0]. The ARCH parameter only
// picks the shape of the network; every branch yields identical results.
module au_prefix_and
    import au_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int ARCH  = AU_ARCH_RIPPLE
) (
    input  logic [WIDTH-1:0] p,
    output logic [WIDTH-1:0] t
);

    localparam int L  = clog2(WIDTH);
    localparam int IW = (L > 0) ? L : 1;

    if (WIDTH < 1 || WIDTH > 64) begin : g_bad_width
        $fatal(1, "au_prefix_and: WIDTH %0d outside 1..64", WIDTH);
    end

    if (ARCH < AU_ARCH_RIPPLE || ARCH > AU_ARCH_BRENT_KUNG) begin : g_bad_arch
        $fatal(1, "au_prefix_and: unsupported ARCH %0d", ARCH);
    end else if (WIDTH == 1) begin : g_w1
        // A single bit always toggles; the operand itself is irrelevant.
        logic unused_p;
        assign unused_p = ^p;
        assign t = 1'b1;
    end else begin : g_net
        // g is the inclusive prefix; t is g shifted up one place.
        logic [WIDTH-1:0] g;
        logic             unused_top;
        assign t          = {g[WIDTH-2:0], 1'b1};
        assign unused_top = g[WIDTH-1];

        if (ARCH == AU_ARCH_RIPPLE) begin : g_ripple
            // Linear AND chain, one gate per bit.
            always_comb begin
                logic acc;
                g   = '0;
                acc = 1'b1;
                for (int i = 0; i < WIDTH; i++) begin
                    acc  = acc & p[i];
                    g[i] = acc;
                end
            end
        end else if (ARCH == AU_ARCH_SKLANSKY) begin : g_sklansky
            // Divide and conquer: upper half of each 2^(l+1) block takes the
            // last bit of its lower half; fan-out doubles per level.
            always_comb begin
                logic [WIDTH-1:0] cur, nxt;
                cur = p;
                for (int l = 0; l < L; l++) begin
                    nxt = cur;
                    for (int i = 0; i < WIDTH; i++)
                        if (((i >> l) & 1) == 1)
                            nxt[i] = cur[i] & cur[IW'(((i >> l) << l) - 1)];
                    cur = nxt;
                end
                g = cur;
            end
        end else if (ARCH == AU_ARCH_KOGGE_STONE) begin : g_kogge_stone
            // Every bit combines with the one 2^l below it; fan-out of two.
            always_comb begin
                logic [WIDTH-1:0] cur, nxt;
                cur = p;
                for (int l = 0; l < L; l++) begin
                    nxt = cur;
                    for (int i = 0; i < WIDTH; i++)
                        if (i >= (1 << l))
                            nxt[i] = cur[i] & cur[IW'(i - (1 << l))];
                    cur = nxt;
                end
                g = cur;
            end
        end else begin : g_brent_kung
            // Up-sweep builds block prefixes at 2^k-1 positions, down-sweep
            // fills the remaining bits from the nearest completed prefix.
            always_comb begin
                logic [WIDTH-1:0] cur, nxt;
                cur = p;
                for (int l = 0; l < L; l++) begin
                    nxt = cur;
                    for (int i = 0; i < WIDTH; i++)
                        if (((i + 1) % (2 << l)) == 0)
                            nxt[i] = cur[i] & cur[IW'(i - (1 << l))];
                    cur = nxt;
                end
                for (int d = L - 2; d >= 0; d--) begin
                    nxt = cur;
                    for (int i = 0; i < WIDTH; i++)
                        if (((i + 1) % (2 << d)) == (1 << d) && (i + 1) > (1 << d))
                            nxt[i] = cur[i] & cur[IW'(i - (1 << d))];
                    cur = nxt;
                end
                g = cur;
            end
        end
    end

endmodule

// File: rtl/au_incdec.sv
// Increment / decrement by one modulo 2^WIDTH with a selectable prefix-AND
// network and an optional output register.
module au_incdec
    import au_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int ARCH    = AU_ARCH_RIPPLE,
    parameter int OUT_REG = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic             inc_dec,
    output logic [WIDTH-1:0] z
);

    logic [WIDTH-1:0] p;
    logic [WIDTH-1:0] t;
    logic [WIDTH-1:0] z_d;

    // Increment toggles above a run of ones, decrement above a run of zeros;
    // inverting a for decrement turns both into a run-of-ones detect.
    assign p = a ^ {WIDTH{inc_dec}};

    au_prefix_and #(
        .WIDTH (WIDTH),
        .ARCH  (ARCH)
    ) u_prefix (
        .p (p),
        .t (t)
    );

    assign z_d = a ^ t;

    if (OUT_REG != 0) begin : g_reg
        logic [WIDTH-1:0] z_q;

        // Output register, reset wins over new data.
        always_ff @(posedge clk) begin
            if (rst) z_q <= '0;
            else     z_q <= z_d;
        end

        assign z = z_q;
    end else begin : g_comb
        logic unused_clk_rst;
        assign unused_clk_rst = clk ^ rst;
        assign z              = z_d;
    end

endmodule

// File: tb/tb_au_incdec.sv
// Bench for au_incdec: every architecture at widths 1, 2, 5, 8 and 32 in
// combinational mode against a + / - 1 masked to WIDTH, plus directed
// vectors and a registered-output sequence at width 8.
module tb_au_incdec;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] model(input logic [63:0] v, input logic dec, input int w);
        logic [63:0] r;
        r = dec ? v - 64'd1 : v + 64'd1;
        return r & ((64'd1 << w) - 64'd1);
    endfunction

    // Combinational instances, one per architecture per width.
    logic [0:0]  a1;  logic id1;  logic [3:0][0:0]  z1;
    logic [1:0]  a2;  logic id2;  logic [3:0][1:0]  z2;
    logic [4:0]  a5;  logic id5;  logic [3:0][4:0]  z5;
    logic [7:0]  a8;  logic id8;  logic [3:0][7:0]  z8;
    logic [31:0] a32; logic id32; logic [3:0][31:0] z32;

    for (genvar g = 0; g < 4; g++) begin : g_arch
        au_incdec #(.WIDTH(1),  .ARCH(g), .OUT_REG(0)) u_w1  (.clk(clk), .rst(rst), .a(a1),  .inc_dec(id1),  .z(z1[g]));
        au_incdec #(.WIDTH(2),  .ARCH(g), .OUT_REG(0)) u_w2  (.clk(clk), .rst(rst), .a(a2),  .inc_dec(id2),  .z(z2[g]));
        au_incdec #(.WIDTH(5),  .ARCH(g), .OUT_REG(0)) u_w5  (.clk(clk), .rst(rst), .a(a5),  .inc_dec(id5),  .z(z5[g]));
        au_incdec #(.WIDTH(8),  .ARCH(g), .OUT_REG(0)) u_w8  (.clk(clk), .rst(rst), .a(a8),  .inc_dec(id8),  .z(z8[g]));
        au_incdec #(.WIDTH(32), .ARCH(g), .OUT_REG(0)) u_w32 (.clk(clk), .rst(rst), .a(a32), .inc_dec(id32), .z(z32[g]));
    end

    // Registered instance.
    logic [7:0] ar;
    logic       idr;
    logic [7:0] zr;

    au_incdec #(.WIDTH(8), .ARCH(3), .OUT_REG(1)) u_reg (
        .clk     (clk),
        .rst     (rst),
        .a       (ar),
        .inc_dec (idr),
        .z       (zr)
    );

    task automatic vec8(input logic [7:0] v, input logic dec, input logic [7:0] exp);
        a8 = v; id8 = dec;
        #1;
        for (int g = 0; g < 4; g++)
            check($sformatf("dir8 arch%0d a=%0h dec=%0b", g, v, dec), z8[g], exp);
    endtask

    task automatic vec32(input logic [31:0] v, input logic dec, input logic [31:0] exp);
        a32 = v; id32 = dec;
        #1;
        for (int g = 0; g < 4; g++)
            check($sformatf("dir32 arch%0d a=%0h dec=%0b", g, v, dec), z32[g], exp);
    endtask

    initial begin
        ar = 8'h55; idr = 1'b0;
        a1 = '0; id1 = 1'b0; a2 = '0; id2 = 1'b0; a5 = '0; id5 = 1'b0;
        a8 = '0; id8 = 1'b0; a32 = '0; id32 = 1'b0;

        // Hand-computed vectors, including both wrap boundaries.
        vec8(8'h7F, 1'b0, 8'h80);
        vec8(8'h80, 1'b1, 8'h7F);
        vec8(8'hFF, 1'b0, 8'h00);
        vec8(8'h00, 1'b1, 8'hFF);
        vec8(8'h00, 1'b0, 8'h01);
        vec8(8'hFF, 1'b1, 8'hFE);
        vec8(8'h57, 1'b0, 8'h58);
        vec8(8'hA8, 1'b1, 8'hA7);
        vec32(32'h0000FFFF, 1'b0, 32'h00010000);
        vec32(32'h00000000, 1'b0, 32'h00000001);
        vec32(32'h00000000, 1'b1, 32'hFFFFFFFF);
        vec32(32'hFFFFFFFF, 1'b0, 32'h00000000);
        vec32(32'hFFFFFFFF, 1'b1, 32'hFFFFFFFE);
        vec32(32'h80000000, 1'b1, 32'h7FFFFFFF);

        // Width 1: z = ~a in both modes; width 2: 2'b10 dec -> 2'b01.
        for (int id = 0; id < 2; id++) begin
            id1 = id[0];
            a1 = 1'b1; #1;
            for (int g = 0; g < 4; g++) check($sformatf("w1 arch%0d a=1 dec=%0d", g, id), z1[g], 1'b0);
            a1 = 1'b0; #1;
            for (int g = 0; g < 4; g++) check($sformatf("w1 arch%0d a=0 dec=%0d", g, id), z1[g], 1'b1);
        end
        a2 = 2'b10; id2 = 1'b1; #1;
        for (int g = 0; g < 4; g++) check($sformatf("w2 arch%0d 10 dec", g), z2[g], 2'b01);

        // Exhaustive sweeps at the small widths.
        for (int v = 0; v < 256; v++)
            for (int id = 0; id < 2; id++) begin
                a2 = v[1:0]; id2 = id[0];
                a5 = v[4:0]; id5 = id[0];
                a8 = v[7:0]; id8 = id[0];
                #1;
                for (int g = 0; g < 4; g++) begin
                    if (v < 4)
                        check($sformatf("w2 arch%0d a=%0h dec=%0d", g, v, id), z2[g], model(64'(v), id[0], 2));
                    if (v < 32)
                        check($sformatf("w5 arch%0d a=%0h dec=%0d", g, v, id), z5[g], model(64'(v), id[0], 5));
                    check($sformatf("w8 arch%0d a=%0h dec=%0d", g, v, id), z8[g], model(64'(v), id[0], 8));
                end
            end

        // Random width-32 operands.
        for (int n = 0; n < 10000; n++) begin
            a32  = $urandom;
            id32 = 1'($urandom_range(0, 1));
            #1;
            for (int g = 0; g < 4; g++)
                check($sformatf("w32 arch%0d a=%0h dec=%0b", g, a32, id32), z32[g], model(64'(a32), id32, 32));
        end

        // Registered output: reset, one-cycle latency, back-to-back, mid-stream reset.
        @(negedge clk);
        rst = 1'b1; ar = 8'h55; idr = 1'b0;
        repeat (3) @(posedge clk);
        #1 check("reg after reset", zr, 8'h00);
        @(negedge clk);
        rst = 1'b0; ar = 8'h41; idr = 1'b0;
        #1 check("reg before first edge", zr, 8'h00);
        @(posedge clk);
        #1 check("reg 41 inc", zr, 8'h42);
        @(negedge clk);
        ar = 8'h10; idr = 1'b1;
        @(posedge clk);
        #1 check("reg 10 dec", zr, 8'h0F);
        @(negedge clk);
        idr = 1'b0;
        @(posedge clk);
        #1 check("reg 10 inc", zr, 8'h11);
        @(negedge clk);
        rst = 1'b1; ar = 8'h33;
        @(posedge clk);
        #1 check("reg mid reset", zr, 8'h00);
        @(negedge clk);
        rst = 1'b0; ar = 8'h7F; idr = 1'b0;
        @(posedge clk);
        #1 check("reg 7F inc after reset", zr, 8'h80);
        @(negedge clk);
        ar = 8'h00; idr = 1'b1;
        @(posedge clk);
        #1 check("reg 00 dec wrap", zr, 8'hFF);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
